// File: rtl/cprv_wb_stage.sv
// cprv64g write-back stage: selects the ALU result or extracted load data and
// presents it to the register file over a registered valid/ready write port.
module cprv_wb_stage #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned IMM_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_wb_i,
  output logic                  ready_wb_o,
  input  logic [DATA_WIDTH-1:0] rs1_data_wb_i,
  input  logic [DATA_WIDTH-1:0] rs2_data_wb_i,
  input  logic [4:0]            rd_addr_wb_i,
  input  logic                  rd_en_wb_i,
  input  logic [IMM_WIDTH-1:0]  imm_data_wb_i,
  input  logic [6:0]            opcode_wb_i,
  input  logic [2:0]            funct3_wb_i,
  input  logic [6:0]            funct7_wb_i,
  input  logic                  w_en_wb_i,
  input  logic [DATA_WIDTH-1:0] alu_out_wb_i,
  input  logic [DATA_WIDTH-1:0] mem_data_wb_i,
  output logic                  valid_rf_o,
  input  logic                  ready_rf_i,
  output logic [4:0]            rd_addr_rf_o,
  output logic [DATA_WIDTH-1:0] rd_data_rf_o,
  output logic                  retire_o,
  output logic [63:0]           instret_o
);

  localparam logic [6:0] OP_LOAD = 7'b0000011;

  typedef enum logic [2:0] {
    LD_B  = 3'b000,
    LD_H  = 3'b001,
    LD_W  = 3'b010,
    LD_D  = 3'b011,
    LD_BU = 3'b100,
    LD_HU = 3'b101,
    LD_WU = 3'b110,
    LD_NA = 3'b111
  } load_size_t;

  logic                  cke;
  logic                  accept;
  logic [2:0]            off;
  logic [DATA_WIDTH-1:0] byte_sh;
  logic [DATA_WIDTH-1:0] half_sh;
  logic [DATA_WIDTH-1:0] word_sh;
  logic [DATA_WIDTH-1:0] load_data;
  logic [DATA_WIDTH-1:0] result;
  load_size_t            load_size;

  logic unused_inputs;
  assign unused_inputs = ^{rs1_data_wb_i, rs2_data_wb_i, imm_data_wb_i,
                           funct7_wb_i, w_en_wb_i, alu_out_wb_i[DATA_WIDTH-1:3]};

  assign cke        = ~valid_rf_o | ready_rf_i;
  assign ready_wb_o = cke & ~rst;
  assign accept     = valid_wb_i & ready_wb_o;

  // Misaligned offsets simply truncate to the containing naturally-aligned lane.
  assign off       = alu_out_wb_i[2:0];
  assign load_size = load_size_t'(funct3_wb_i);
  assign byte_sh   = mem_data_wb_i >> {off, 3'b000};
  assign half_sh   = mem_data_wb_i >> {off[2:1], 4'b0000};
  assign word_sh   = mem_data_wb_i >> {off[2], 5'b00000};

  always_comb begin
    load_data = '0;
    unique case (load_size)
      LD_B:  load_data = {{(DATA_WIDTH-8){byte_sh[7]}}, byte_sh[7:0]};
      LD_H:  load_data = {{(DATA_WIDTH-16){half_sh[15]}}, half_sh[15:0]};
      LD_W:  load_data = {{(DATA_WIDTH-32){word_sh[31]}}, word_sh[31:0]};
      LD_D:  load_data = mem_data_wb_i;
      LD_BU: load_data = {{(DATA_WIDTH-8){1'b0}}, byte_sh[7:0]};
      LD_HU: load_data = {{(DATA_WIDTH-16){1'b0}}, half_sh[15:0]};
      LD_WU: load_data = {{(DATA_WIDTH-32){1'b0}}, word_sh[31:0]};
      LD_NA: load_data = '0;
      default: load_data = '0;
    endcase
  end

  always_comb begin
    result = alu_out_wb_i;
    if (opcode_wb_i == OP_LOAD) result = load_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_rf_o   <= 1'b0;
      rd_addr_rf_o <= '0;
      rd_data_rf_o <= '0;
      retire_o     <= 1'b0;
      instret_o    <= '0;
    end else begin
      retire_o <= accept;
      if (accept) instret_o <= instret_o + 64'd1;
      if (cke) begin
        valid_rf_o   <= valid_wb_i & rd_en_wb_i & (rd_addr_wb_i != 5'd0);
        rd_addr_rf_o <= rd_addr_wb_i;
        rd_data_rf_o <= result;
      end
    end
  end

endmodule

// File: tb/tb_cprv_wb_stage.sv
// Directed bench for cprv_wb_stage: result selection, load lanes, x0 handling,
// backpressure, streaming throughput, counter wrap and mid-stall reset.
module tb_cprv_wb_stage;

  localparam logic [6:0] OP_ALU   = 7'b0110011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [63:0] DWORD   = 64'h8877_6655_4433_2281;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_wb_i;
  logic        ready_wb_o;
  logic [63:0] rs1_data_wb_i, rs2_data_wb_i;
  logic [4:0]  rd_addr_wb_i;
  logic        rd_en_wb_i;
  logic [31:0] imm_data_wb_i;
  logic [6:0]  opcode_wb_i;
  logic [2:0]  funct3_wb_i;
  logic [6:0]  funct7_wb_i;
  logic        w_en_wb_i;
  logic [63:0] alu_out_wb_i;
  logic [63:0] mem_data_wb_i;
  logic        valid_rf_o;
  logic        ready_rf_i;
  logic [4:0]  rd_addr_rf_o;
  logic [63:0] rd_data_rf_o;
  logic        retire_o;
  logic [63:0] instret_o;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [63:0] exp_instret;

  cprv_wb_stage #(.DATA_WIDTH(64), .IMM_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .valid_wb_i(valid_wb_i), .ready_wb_o(ready_wb_o),
    .rs1_data_wb_i(rs1_data_wb_i), .rs2_data_wb_i(rs2_data_wb_i),
    .rd_addr_wb_i(rd_addr_wb_i), .rd_en_wb_i(rd_en_wb_i),
    .imm_data_wb_i(imm_data_wb_i), .opcode_wb_i(opcode_wb_i),
    .funct3_wb_i(funct3_wb_i), .funct7_wb_i(funct7_wb_i),
    .w_en_wb_i(w_en_wb_i), .alu_out_wb_i(alu_out_wb_i),
    .mem_data_wb_i(mem_data_wb_i),
    .valid_rf_o(valid_rf_o), .ready_rf_i(ready_rf_i),
    .rd_addr_rf_o(rd_addr_rf_o), .rd_data_rf_o(rd_data_rf_o),
    .retire_o(retire_o), .instret_o(instret_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd,
                         input logic en, input logic [63:0] alu, input logic [63:0] mem);
    valid_wb_i    = 1'b1;
    opcode_wb_i   = op;
    funct3_wb_i   = f3;
    rd_addr_wb_i  = rd;
    rd_en_wb_i    = en;
    w_en_wb_i     = (op == OP_STORE);
    alu_out_wb_i  = alu;
    mem_data_wb_i = mem;
  endtask

  // Present, accept on one edge, then drop valid.
  task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd,
                       input logic en, input logic [63:0] alu, input logic [63:0] mem);
    present(op, f3, rd, en, alu, mem);
    tick();
    valid_wb_i = 1'b0;
    exp_instret = exp_instret + 64'd1;
  endtask

  task automatic load_check(input string tag, input logic [2:0] f3, input logic [63:0] alu,
                            input logic [63:0] exp);
    issue(OP_LOAD, f3, 5'd10, 1'b1, alu, DWORD);
    check({tag, "_valid"}, {63'd0, valid_rf_o}, 64'd1);
    check({tag, "_data"}, rd_data_rf_o, exp);
  endtask

  initial begin
    rst = 1'b1; valid_wb_i = 1'b0; ready_rf_i = 1'b1;
    rs1_data_wb_i = 64'hDEAD; rs2_data_wb_i = 64'hBEEF; imm_data_wb_i = '0;
    funct7_wb_i = '0; rd_addr_wb_i = '0; rd_en_wb_i = 1'b0; opcode_wb_i = OP_ALU;
    funct3_wb_i = '0; w_en_wb_i = 1'b0; alu_out_wb_i = '0; mem_data_wb_i = '0;
    exp_instret = '0;

    tick(); tick();
    check("rst_ready", {63'd0, ready_wb_o}, 64'd0);
    check("rst_valid", {63'd0, valid_rf_o}, 64'd0);
    check("rst_addr", {59'd0, rd_addr_rf_o}, 64'd0);
    check("rst_data", rd_data_rf_o, 64'd0);
    check("rst_retire", {63'd0, retire_o}, 64'd0);
    check("rst_instret", instret_o, 64'd0);
    rst = 1'b0;
    #1;
    check("ready_after_rst", {63'd0, ready_wb_o}, 64'd1);

    issue(OP_ALU, 3'b000, 5'd5, 1'b1, 64'h1234, 64'h0);
    check("add_valid", {63'd0, valid_rf_o}, 64'd1);
    check("add_addr", {59'd0, rd_addr_rf_o}, 64'd5);
    check("add_data", rd_data_rf_o, 64'h1234);
    check("add_retire", {63'd0, retire_o}, 64'd1);
    check("add_instret", instret_o, 64'd1);
    tick();
    check("idle_valid", {63'd0, valid_rf_o}, 64'd0);
    check("idle_retire", {63'd0, retire_o}, 64'd0);

    load_check("lb",  3'b000, 64'h1000, 64'hFFFF_FFFF_FFFF_FF81);
    load_check("lbu", 3'b100, 64'h1000, 64'h0000_0000_0000_0081);
    load_check("lh6", 3'b001, 64'h1006, 64'hFFFF_FFFF_FFFF_8877);
    load_check("lh2", 3'b001, 64'h1002, 64'h0000_0000_0000_4433);
    load_check("lw0", 3'b010, 64'h1000, 64'h0000_0000_4433_2281);
    load_check("lw4", 3'b010, 64'h1004, 64'hFFFF_FFFF_8877_6655);
    load_check("lwu", 3'b110, 64'h1004, 64'h0000_0000_8877_6655);
    load_check("lbu_mis", 3'b100, 64'h1007, 64'h0000_0000_0000_0088);
    load_check("lhu_mis", 3'b101, 64'h1003, 64'h0000_0000_0000_4433);
    load_check("ld",  3'b011, 64'h1000, DWORD);
    load_check("f7",  3'b111, 64'h1000, 64'h0);
    check("load_instret", instret_o, exp_instret);

    issue(OP_ALU, 3'b000, 5'd0, 1'b1, 64'h5, 64'h0);
    check("x0_valid", {63'd0, valid_rf_o}, 64'd0);
    check("x0_retire", {63'd0, retire_o}, 64'd1);
    issue(OP_STORE, 3'b010, 5'd3, 1'b0, 64'h2000, 64'h0);
    check("sw_valid", {63'd0, valid_rf_o}, 64'd0);
    check("sw_retire", {63'd0, retire_o}, 64'd1);
    check("x0_sw_instret", instret_o, exp_instret);

    issue(OP_LOAD, 3'b011, 5'd7, 1'b1, 64'h3000, DWORD);
    ready_rf_i = 1'b0;
    present(OP_ALU, 3'b000, 5'd8, 1'b1, 64'hABC, 64'h0);
    #1;
    check("bp_ready", {63'd0, ready_wb_o}, 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_valid", {63'd0, valid_rf_o}, 64'd1);
      check("bp_addr", {59'd0, rd_addr_rf_o}, 64'd7);
      check("bp_data", rd_data_rf_o, DWORD);
      check("bp_retire", {63'd0, retire_o}, 64'd0);
      check("bp_ready_hold", {63'd0, ready_wb_o}, 64'd0);
    end
    ready_rf_i = 1'b1;
    #1;
    check("bp_release_ready", {63'd0, ready_wb_o}, 64'd1);
    tick();
    valid_wb_i = 1'b0;
    exp_instret = exp_instret + 64'd1;
    check("bp_next_valid", {63'd0, valid_rf_o}, 64'd1);
    check("bp_next_addr", {59'd0, rd_addr_rf_o}, 64'd8);
    check("bp_next_data", rd_data_rf_o, 64'hABC);
    check("bp_next_retire", {63'd0, retire_o}, 64'd1);
    check("bp_instret", instret_o, exp_instret);

    for (int i = 0; i < 10; i++) begin
      present(OP_ALU, 3'b000, 5'(i + 1), 1'b1, 64'h100 + 64'(i), 64'h0);
      tick();
      exp_instret = exp_instret + 64'd1;
      check("stream_valid", {63'd0, valid_rf_o}, 64'd1);
      check("stream_addr", {59'd0, rd_addr_rf_o}, 64'(i + 1));
      check("stream_data", rd_data_rf_o, 64'h100 + 64'(i));
      check("stream_retire", {63'd0, retire_o}, 64'd1);
    end
    valid_wb_i = 1'b0;
    check("stream_instret", instret_o, exp_instret);
    tick();

    force dut.instret_o = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.instret_o;
    #1;
    issue(OP_ALU, 3'b000, 5'd2, 1'b1, 64'h9, 64'h0);
    check("wrap_instret", instret_o, 64'd0);

    issue(OP_ALU, 3'b000, 5'd4, 1'b1, 64'h44, 64'h0);
    ready_rf_i = 1'b0;
    rst = 1'b1;
    #1;
    check("midrst_ready", {63'd0, ready_wb_o}, 64'd0);
    tick();
    check("midrst_valid", {63'd0, valid_rf_o}, 64'd0);
    check("midrst_instret", instret_o, 64'd0);
    check("midrst_data", rd_data_rf_o, 64'd0);
    rst = 1'b0;
    ready_rf_i = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
